decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_W, default 1, meaning entry-index width (buffer holds at most 2 entries; fixed, not user-scalable).
REQ-002 SHALL have port clk  input  1  single system clock; all state rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports in_valid  input  1, and in_ready  output  1, forming the fetch-side handshake.
REQ-005 SHALL have ports in_instr  input  32, and in_pc  input  32, carrying the fetched word and its address.
REQ-006 SHALL have port flush  input  1  redirect; kills all buffered entries.
REQ-007 SHALL have ports out_valid  output  1, and out_ready  input  1, forming the execute-side handshake.
REQ-008 SHALL have ports out_instr  output  32, and out_pc  output  32, carrying the head entry.
REQ-009 SHALL have port out_imm  output  32  sign/zero-formatted immediate of the head entry.
REQ-010 SHALL have port out_target  output  32  out_pc + out_imm, modulo 2^32.
REQ-011 SHALL have port out_is_ctrl  output  1  head opcode is branch (1100011), JAL (1101111) or JALR (1100111).

Function
REQ-012 SHALL transfer on in side when in_valid && in_ready, and on out side when out_valid && out_ready.
REQ-013 SHALL implement states EMPTY (0 entries), HALF (1), FULL (2); out_valid = (state != EMPTY).
REQ-014 SHALL move EMPTY->HALF on in-transfer; HALF->FULL on in-transfer without out-transfer; HALF->EMPTY on out-transfer without in-transfer; FULL->HALF on out-transfer; otherwise hold.
REQ-015 SHALL assert in_ready = (state != FULL), registered, not combinationally dependent on out_ready.
REQ-016 SHALL present an accepted word at the outputs no earlier than the cycle after acceptance (latency 1) and preserve FIFO order.
REQ-017 SHALL compute the immediate from the head word: I-type for opcodes 0010011, 0000011, 1100111; S-type for 0100011; B-type for 1100011; U-type for 0110111; J-type for 1101111; 32'h0 for any other opcode.
REQ-018 SHALL sign-extend from instr[31] for I/S/B/J, append a zero LSB for B/J, and append 12 zero bits for U.
REQ-019 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-020 SHALL, on flush, go to EMPTY the next cycle, discard any same-cycle in-transfer, and ignore a same-cycle out_ready.
REQ-021 SHALL treat flush in EMPTY as a no-op.

Reset
REQ-022 SHALL, while rst_n is low, force state EMPTY, out_valid 0, in_ready 0, and out_instr/out_pc/out_imm/out_target 32'h0, out_is_ctrl 0.
REQ-023 SHALL raise in_ready on the first clk edge after rst_n deasserts; reset mid-transfer SHALL discard all entries.

Configuration
REQ-024 SHALL use macro DECODE_SEQ_TARGET_EN: when defined, out_target is computed as in REQ-010; when undefined, the adder is omitted and out_target is tied to 32'h0.

Structure
REQ-025 SHALL place opcode localparams (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR) and a state enum type in a shared package decode_pkg.
REQ-026 SHALL instantiate one combinational sub-module imm_extract (instr in, imm out) on the head entry.

Verification
REQ-027 SHALL verify: push 0xFFF00093 @pc 0x0, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_is_ctrl=0.
REQ-028 SHALL verify: push 0x008000EF @pc 0x100 -> out_imm=0x8, out_target=0x108, out_is_ctrl=1.
REQ-029 SHALL verify: push 0xFE000EE3 @pc 0x200 -> out_imm=0xFFFFFFFC, out_target=0x1FC.
REQ-030 SHALL verify: out_ready=0, push 0x12345037 then 0x00000013 -> FULL, in_ready=0, head out_imm=0x12345000 held stable; release -> two words in order.
REQ-031 SHALL verify: FULL, assert flush with in_valid=1 -> next cycle EMPTY, out_valid=0, in_ready=1, no word delivered.
REQ-032 SHALL verify: rst_n low during HALF -> all outputs 0 immediately; after release, out_valid stays 0 until a new push.

Source files
------------

// File: rtl/decode_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_pkg: opcodes, buffer state type and control-op helper for decode_sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
package decode_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_sequencer_if: fetch-side and execute-side handshakes of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface decode_sequencer_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic        out_is_ctrl;

  // Sequencer side.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_is_ctrl
  );

  // Fetch/execute environment side.
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_is_ctrl
  );

endinterface
`default_nettype wire

// File: rtl/decode_sequencer_imm_extract.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_extract: combinational RV32 immediate formatter (I/S/B/U/J, else zero)
// Revision 1.0
// ---------------------------------------------------------------------------
module imm_extract
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = 32'h0;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OP_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OP_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OP_LUI:
        imm_o = {instr_i[31:12], 12'h000};
      OP_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        imm_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_sequencer: 2-entry fetch->execute buffer presenting decoded immediate
// Optional macro DECODE_SEQ_TARGET_EN enables the out_target adder. Rev 1.0
// ---------------------------------------------------------------------------
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int DEPTH_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_sequencer_if.slave bus
);

  localparam int                   DEPTH   = 1 << DEPTH_W;
  localparam logic [DEPTH_W-1:0]   PTR_ONE = DEPTH_W'(1);

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]          instr_q [DEPTH];
  logic [31:0]          pc_q    [DEPTH];

  logic                 push;
  logic                 pop;
  logic [31:0]          head_instr;
  logic [31:0]          head_pc;
  logic [31:0]          head_imm;

  // Flush takes priority over both handshakes in the same cycle.
  always_comb begin
    push       = bus.in_valid && in_ready_q && !bus.flush;
    pop        = (state_q != EMPTY) && bus.out_ready && !bus.flush;
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (bus.flush) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_d = HALF;
        HALF: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = HALF;
        default: state_d = EMPTY;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Ready comes from a flop so it never depends on out_ready in-cycle.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= bus.in_instr;
      pc_q[wr_ptr_q]    <= bus.in_pc;
    end
  end

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];

  imm_extract u_imm_extract (
    .instr_i (head_instr),
    .imm_o   (head_imm)
  );

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_instr   = head_instr;
  assign bus.out_pc      = head_pc;
  assign bus.out_imm     = head_imm;
  assign bus.out_is_ctrl = is_ctrl_op(head_instr[6:0]);

`ifdef DECODE_SEQ_TARGET_EN
  assign bus.out_target  = head_pc + head_imm;
`else
  assign bus.out_target  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_sequencer: directed and randomized checks against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_decode_sequencer;

`ifdef DECODE_SEQ_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  decode_sequencer_if bus ();

  decode_sequencer #(.DEPTH_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Immediate built from field arithmetic on the word.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return (sx << 12) | (w >> 20);
      7'h23: return (sx << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
      7'h63: return (sx << 12) | (((w >> 7) & 32'h1) << 11) |
                    (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      7'h37: return w & 32'hFFFF_F000;
      7'h6F: return (sx << 20) | (w & 32'h000F_F000) |
                    (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_ctrl(input logic [31:0] w);
    return (w[6:0] == 7'h63) || (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_vec++; if ({bus.out_instr, bus.out_pc, bus.out_imm, bus.out_target} !== 128'h0) begin n_err++; $display("FAIL rst_data: got %h %h %h %h want 0", bus.out_instr, bus.out_pc, bus.out_imm, bus.out_target); end
    n_vec++; if (bus.out_is_ctrl !== 1'b0) begin n_err++; $display("FAIL rst_is_ctrl: got %b want 0", bus.out_is_ctrl); end
    rst_n = 1'b1;
    cyc();
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_directed();
    logic [31:0] wd [3];
    logic [31:0] pd [3];
    logic [31:0] id [3];
    logic [31:0] td [3];
    logic        cd [3];
    wd = '{32'hFFF00093, 32'h008000EF, 32'hFE000EE3};
    pd = '{32'h0, 32'h100, 32'h200};
    id = '{32'hFFFF_FFFF, 32'h8, 32'hFFFF_FFFC};
    td = '{32'hFFFF_FFFF, 32'h108, 32'h1FC};
    cd = '{1'b0, 1'b1, 1'b1};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = wd[k]; bus.in_pc = pd[k];
      cyc();
      bus.in_valid = 1'b0;
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid: got %b want 1", k, bus.out_valid); end
      n_vec++; if (bus.out_instr !== wd[k] || bus.out_pc !== pd[k]) begin n_err++; $display("FAIL dir%0d_word: got %h@%h want %h@%h", k, bus.out_instr, bus.out_pc, wd[k], pd[k]); end
      n_vec++; if (bus.out_imm !== id[k]) begin n_err++; $display("FAIL dir%0d_imm: got %h want %h", k, bus.out_imm, id[k]); end
      n_vec++; if (bus.out_target !== (TGT_EN ? td[k] : 32'h0)) begin n_err++; $display("FAIL dir%0d_target: got %h want %h", k, bus.out_target, TGT_EN ? td[k] : 32'h0); end
      n_vec++; if (bus.out_is_ctrl !== cd[k]) begin n_err++; $display("FAIL dir%0d_ctrl: got %b want %b", k, bus.out_is_ctrl, cd[k]); end
      cyc();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_drain: got %b want 0", k, bus.out_valid); end
    end
  endtask

  task automatic test_full_stall();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h12345037; bus.in_pc = 32'h300;
    cyc();
    bus.in_instr = 32'h00000013; bus.in_pc = 32'h304;
    cyc();
    bus.in_instr = 32'hDEADBEEF; bus.in_pc = 32'h308;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready%0d: got %b want 0", k, bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h12345037 || bus.out_imm !== 32'h12345000) begin n_err++; $display("FAIL full_hold%0d: got v=%b %h imm=%h want v=1 12345037 imm=12345000", k, bus.out_valid, bus.out_instr, bus.out_imm); end
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00000013 || bus.out_pc !== 32'h304) begin n_err++; $display("FAIL full_second: got v=%b %h@%h want v=1 00000013@304", bus.out_valid, bus.out_instr, bus.out_pc); end
    n_vec++; if (bus.out_imm !== 32'h0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_second_imm: got imm=%h rdy=%b want 0 1", bus.out_imm, bus.in_ready); end
    cyc();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL full_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = 32'h400;
    cyc();
    bus.in_instr = 32'h00200113; bus.in_pc = 32'h404;
    cyc();
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full: got rdy=%b want 0", bus.in_ready); end
    bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_instr = 32'h00300193; bus.in_pc = 32'h408;
    cyc();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_empty: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    cyc();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_word: got %b want 0", bus.out_valid); end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_noop: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0040006F; bus.in_pc = 32'h500;
    cyc();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_half: got %b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_is_ctrl !== 1'b0) begin n_err++; $display("FAIL rmid_ctl: got v=%b rdy=%b c=%b want 0 0 0", bus.out_valid, bus.in_ready, bus.out_is_ctrl); end
    n_vec++; if ({bus.out_instr, bus.out_pc, bus.out_imm, bus.out_target} !== 128'h0) begin n_err++; $display("FAIL rmid_data: got %h %h %h %h want 0", bus.out_instr, bus.out_pc, bus.out_imm, bus.out_target); end
    cyc(); cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_release: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    cyc();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stay_empty: got %b want 0", bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_instr = 32'h00A00513; bus.in_pc = 32'h600;
    cyc();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00A00513 || bus.out_imm !== 32'hA) begin n_err++; $display("FAIL rmid_new_push: got v=%b %h imm=%h want 1 00A00513 0000000a", bus.out_valid, bus.out_instr, bus.out_imm); end
    cyc();
  endtask

  task automatic test_random(input int n);
    logic [31:0] qi [$];
    logic [31:0] qp [$];
    logic [6:0]  ops [10];
    logic [31:0] r, w, ei, et;
    logic        do_push, do_pop;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33, 7'h17, 7'h00};
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    for (int k = 0; k < n; k++) begin
      n_vec++; if (bus.out_valid !== (qi.size() != 0)) begin n_err++; $display("FAIL rnd%0d_valid: got %b want %b", k, bus.out_valid, qi.size() != 0); end
      n_vec++; if (bus.in_ready !== (qi.size() < 2)) begin n_err++; $display("FAIL rnd%0d_ready: got %b want %b", k, bus.in_ready, qi.size() < 2); end
      if (qi.size() != 0) begin
        ei = ref_imm(qi[0]);
        et = TGT_EN ? qp[0] + ei : 32'h0;
        n_vec++; if (bus.out_instr !== qi[0] || bus.out_pc !== qp[0]) begin n_err++; $display("FAIL rnd%0d_word: got %h@%h want %h@%h", k, bus.out_instr, bus.out_pc, qi[0], qp[0]); end
        n_vec++; if (bus.out_imm !== ei || bus.out_target !== et) begin n_err++; $display("FAIL rnd%0d_imm: got %h/%h want %h/%h", k, bus.out_imm, bus.out_target, ei, et); end
        n_vec++; if (bus.out_is_ctrl !== ref_ctrl(qi[0])) begin n_err++; $display("FAIL rnd%0d_ctrl: got %b want %b", k, bus.out_is_ctrl, ref_ctrl(qi[0])); end
      end
      r = $urandom;
      w = $urandom;
      bus.in_valid  = r[0];
      bus.out_ready = r[1] | r[2];
      bus.flush     = (r[7:3] == 5'd0);
      bus.in_instr  = {w[31:7], ops[$urandom_range(0, 9)]};
      bus.in_pc     = $urandom;
      do_push = bus.in_valid && (qi.size() < 2) && !bus.flush;
      do_pop  = (qi.size() != 0) && bus.out_ready && !bus.flush;
      if (do_push) begin
        w = bus.in_instr;
        r = bus.in_pc;
      end
      cyc();
      if (bus.flush) begin
        qi.delete(); qp.delete();
      end else begin
        if (do_pop) begin void'(qi.pop_front()); void'(qp.pop_front()); end
        if (do_push) begin qi.push_back(w); qp.push_back(r); end
      end
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_full_stall();
    test_flush();
    test_reset_mid();
    test_random(800);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
